raster_span_engine: RTL and testbench

- Parametrised successor to the single-pixel rasteriser: accepts screen-space integer triangles over a valid/ready handshake.
- Walks each triangle's clamped bounding box LANES pixels per cycle, using incrementally updated edge functions.
- Performs a pipelined z-buffer read-compare-write and issues masked LANES-wide framebuffer writes.
- Sits between the vertex transform/divide stage (upstream) and the framebuffer/z-buffer RAMs (downstream).

---
 rtl/raster_pkg.sv | 34 +++
 rtl/edge_stepper.sv | 41 ++++
 rtl/raster_span_engine.sv | 198 +++++++++++++++++++
 tb/tb_raster_span_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: shared state/vertex/triangle types, edge width and edge-function helper
// for raster_span_engine and its edge_stepper.
package raster_pkg;
    localparam int COORD_W = 12;
    localparam int Z_W = 16;
    localparam int COLOR_W = 16;
    localparam int EDGE_BITS = 2 * COORD_W + 2;

    typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} raster_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } int_vertex_t;

    typedef struct packed {
        int_vertex_t a;
        int_vertex_t b;
        int_vertex_t c;
        logic [Z_W-1:0] z;
        logic [COLOR_W-1:0] color;
    } raster_tri_t;

    typedef logic signed [EDGE_BITS-1:0] edge_t;

    function automatic edge_t sx(input logic signed [COORD_W-1:0] v);
        return EDGE_BITS'(v);
    endfunction

    // Edge function of p0->p1 evaluated at (px, py); the triangle interior is >= 0 on all edges.
    function automatic edge_t edge_at(input int_vertex_t p0, input int_vertex_t p1, input edge_t px, input edge_t py);
        return (sx(p1.x) - sx(p0.x)) * (py - sx(p0.y)) - (sx(p1.y) - sx(p0.y)) * (px - sx(p0.x));
    endfunction
endpackage

// File: rtl/edge_stepper.sv
// edge_stepper: one edge function walked across the bounding box; the row-start value
// is kept so starting a new row is a single add instead of undoing the x steps.
module edge_stepper
    import raster_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  step_x,
    input  logic  step_y,
    input  edge_t init,
    input  edge_t dx,
    input  edge_t dy,
    output edge_t value,
    output edge_t dx_q
);
    localparam int SH = $clog2(LANES);

    edge_t row_base, dy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= '0;
            row_base <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (load) begin
            value    <= init;
            row_base <= init;
            dx_q     <= dx;
            dy_q     <= dy;
        end else if (step_y) begin
            value    <= row_base + dy_q;
            row_base <= row_base + dy_q;
        end else if (step_x) begin
            value    <= value + (dx_q <<< SH);
        end
    end
endmodule

// File: rtl/raster_span_engine.sv
// raster_span_engine: LANES-wide span rasteriser with pipelined z-test and masked writes.
// Build option RASTER_BACKFACE_CULL_EN drops area<=0 triangles; otherwise they are drawn two-sided.
module raster_span_engine
    import raster_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 160,
    parameter int DISPLAY_HEIGHT = 120,
    parameter int LANES          = 4,
    parameter int COORD_BITS     = COORD_W,
    parameter int Z_BITS         = Z_W,
    parameter int COLOR_BITS     = COLOR_W,
    parameter int WORD_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT / LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tri_valid,
    output logic                           tri_ready,
    input  logic signed [COORD_BITS-1:0]   tri_ax,
    input  logic signed [COORD_BITS-1:0]   tri_ay,
    input  logic signed [COORD_BITS-1:0]   tri_bx,
    input  logic signed [COORD_BITS-1:0]   tri_by,
    input  logic signed [COORD_BITS-1:0]   tri_cx,
    input  logic signed [COORD_BITS-1:0]   tri_cy,
    input  logic [Z_BITS-1:0]              tri_z,
    input  logic [COLOR_BITS-1:0]          tri_color,
    output logic                           busy,
    output logic                           tri_done,
    output logic                           zbuf_rd_en,
    output logic [WORD_ADDR_BITS-1:0]      zbuf_rd_addr,
    input  logic [LANES*Z_BITS-1:0]        zbuf_rd_data,
    output logic                           zbuf_wr_en,
    output logic [WORD_ADDR_BITS-1:0]      zbuf_wr_addr,
    output logic [LANES*Z_BITS-1:0]        zbuf_wr_data,
    output logic [LANES-1:0]               zbuf_wr_mask,
    output logic                           fb_wr_en,
    output logic [WORD_ADDR_BITS-1:0]      fb_wr_addr,
    output logic [LANES*COLOR_BITS-1:0]    fb_wr_data,
    output logic [LANES-1:0]               fb_wr_mask
);
    localparam int SPAN_WORDS = DISPLAY_WIDTH / LANES;

    typedef logic signed [COORD_BITS-1:0] coord_t;

    function automatic coord_t lo3(input coord_t p, input coord_t q, input coord_t r);
        coord_t m;
        m = p < q ? p : q;
        return m < r ? m : r;
    endfunction

    function automatic coord_t hi3(input coord_t p, input coord_t q, input coord_t r);
        coord_t m;
        m = p > q ? p : q;
        return m > r ? m : r;
    endfunction

    raster_state_t state, state_nx;
    raster_tri_t tri_q;
    int_vertex_t vb, vc;
    coord_t min_x, max_x, min_y, max_y, x_start, x, y;
    coord_t bx0, bx1, by0, by1, xs, lo, hi;
    coord_t lx [LANES];
    edge_t area, ab_i, bc_i, ca_i, ab_dx, bc_dx, ca_dx, ab_dy, bc_dy, ca_dy;
    edge_t ab_e, bc_e, ca_e, ab_dxq, bc_dxq, ca_dxq;
    edge_t ab_l [LANES];
    edge_t bc_l [LANES];
    edge_t ca_l [LANES];
    logic drop, row_end, last_row, load, step_x, step_y, s2_valid;
    logic [LANES-1:0] cov, s2_mask, wmask;
    logic [WORD_ADDR_BITS-1:0] addr, s2_addr;

    always_comb begin
        area = edge_at(tri_q.a, tri_q.b, sx(tri_q.c.x), sx(tri_q.c.y));
`ifdef RASTER_BACKFACE_CULL_EN
        vb = tri_q.b;
        vc = tri_q.c;
        drop = area <= 0;
`else
        vb = area < 0 ? tri_q.c : tri_q.b;
        vc = area < 0 ? tri_q.b : tri_q.c;
        drop = area == 0;
`endif
        lo = lo3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        hi = hi3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        bx0 = lo < 0 ? '0 : lo;
        bx1 = hi > DISPLAY_WIDTH - 1 ? coord_t'(DISPLAY_WIDTH - 1) : hi;
        lo = lo3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
        hi = hi3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
        by0 = lo < 0 ? '0 : lo;
        by1 = hi > DISPLAY_HEIGHT - 1 ? coord_t'(DISPLAY_HEIGHT - 1) : hi;
        drop = drop || bx1 < bx0 || by1 < by0;
        xs = bx0 & ~coord_t'(LANES - 1);
        ab_i = edge_at(tri_q.a, vb, sx(xs), sx(by0));
        bc_i = edge_at(vb, vc, sx(xs), sx(by0));
        ca_i = edge_at(vc, tri_q.a, sx(xs), sx(by0));
        ab_dx = sx(tri_q.a.y) - sx(vb.y);
        bc_dx = sx(vb.y) - sx(vc.y);
        ca_dx = sx(vc.y) - sx(tri_q.a.y);
        ab_dy = sx(vb.x) - sx(tri_q.a.x);
        bc_dy = sx(vc.x) - sx(vb.x);
        ca_dy = sx(tri_q.a.x) - sx(vc.x);
    end

    edge_stepper #(.LANES(LANES)) u_ab (.clk(clk), .rst(rst), .load(load), .step_x(step_x), .step_y(step_y),
        .init(ab_i), .dx(ab_dx), .dy(ab_dy), .value(ab_e), .dx_q(ab_dxq));
    edge_stepper #(.LANES(LANES)) u_bc (.clk(clk), .rst(rst), .load(load), .step_x(step_x), .step_y(step_y),
        .init(bc_i), .dx(bc_dx), .dy(bc_dy), .value(bc_e), .dx_q(bc_dxq));
    edge_stepper #(.LANES(LANES)) u_ca (.clk(clk), .rst(rst), .load(load), .step_x(step_x), .step_y(step_y),
        .init(ca_i), .dx(ca_dx), .dy(ca_dy), .value(ca_e), .dx_q(ca_dxq));

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ab_l[i] = ab_e + ab_dxq * EDGE_BITS'(i);
            bc_l[i] = bc_e + bc_dxq * EDGE_BITS'(i);
            ca_l[i] = ca_e + ca_dxq * EDGE_BITS'(i);
            lx[i] = x + coord_t'(i);
            cov[i] = !ab_l[i][EDGE_BITS-1] && !bc_l[i][EDGE_BITS-1] && !ca_l[i][EDGE_BITS-1]
                     && lx[i] >= min_x && lx[i] <= max_x;
            wmask[i] = s2_mask[i] && tri_q.z < zbuf_rd_data[i*Z_BITS +: Z_BITS];
        end
        addr = WORD_ADDR_BITS'(int'(y) * SPAN_WORDS + int'(x) / LANES);
        row_end = x + coord_t'(LANES) > max_x;
        last_row = y == max_y;
    end

    always_comb begin
        state_nx = state;
        load = 1'b0;
        step_x = 1'b0;
        step_y = 1'b0;
        case (state)
            IDLE:  state_nx = tri_valid ? SETUP : IDLE;
            SETUP: begin
                load = 1'b1;
                state_nx = drop ? DONE : SCAN;
            end
            SCAN:  begin
                step_x = !row_end;
                step_y = row_end && !last_row;
                state_nx = row_end && last_row ? DRAIN : SCAN;
            end
            DRAIN: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tri_q    <= '0;
            min_x    <= '0;
            max_x    <= '0;
            min_y    <= '0;
            max_y    <= '0;
            x_start  <= '0;
            x        <= '0;
            y        <= '0;
            s2_valid <= 1'b0;
            s2_mask  <= '0;
            s2_addr  <= '0;
        end else begin
            state    <= state_nx;
            s2_valid <= state == SCAN;
            s2_mask  <= state == SCAN ? cov : '0;
            s2_addr  <= addr;
            if (state == IDLE && tri_valid)
                tri_q <= '{a: '{x: tri_ax, y: tri_ay}, b: '{x: tri_bx, y: tri_by},
                           c: '{x: tri_cx, y: tri_cy}, z: tri_z, color: tri_color};
            if (load) begin
                min_x   <= bx0;
                max_x   <= bx1;
                min_y   <= by0;
                max_y   <= by1;
                x_start <= xs;
                x       <= xs;
                y       <= by0;
            end else if (step_x) begin
                x <= x + coord_t'(LANES);
            end else if (step_y) begin
                x <= x_start;
                y <= y + coord_t'(1);
            end
        end
    end

    assign tri_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign tri_done     = state == DONE;
    assign zbuf_rd_en   = state == SCAN;
    assign zbuf_rd_addr = zbuf_rd_en ? addr : '0;
    assign zbuf_wr_en   = s2_valid && |wmask;
    assign zbuf_wr_addr = zbuf_wr_en ? s2_addr : '0;
    assign zbuf_wr_data = {LANES{tri_q.z}};
    assign zbuf_wr_mask = wmask;
    assign fb_wr_en     = zbuf_wr_en;
    assign fb_wr_addr   = zbuf_wr_addr;
    assign fb_wr_data   = {LANES{tri_q.color}};
    assign fb_wr_mask   = wmask;
endmodule

// File: tb/tb_raster_span_engine.sv
// tb_raster_span_engine: randomized and directed triangles against a per-pixel reference
// rasteriser with its own z-buffer/framebuffer images.
module tb_raster_span_engine;
    localparam int W = 160;
    localparam int H = 120;
    localparam int L = 4;
    localparam int CB = 12;
    localparam int ZB = 16;
    localparam int KB = 16;
    localparam int AB = $clog2(W * H / L);
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tri_valid = 1'b0;
    logic tri_ready, busy, tri_done;
    logic signed [CB-1:0] tri_ax = '0, tri_ay = '0, tri_bx = '0, tri_by = '0, tri_cx = '0, tri_cy = '0;
    logic [ZB-1:0] tri_z = '0;
    logic [KB-1:0] tri_color = '0;
    logic zbuf_rd_en, zbuf_wr_en, fb_wr_en;
    logic [AB-1:0] zbuf_rd_addr, zbuf_wr_addr, fb_wr_addr;
    logic [L*ZB-1:0] zbuf_rd_data = '0;
    logic [L*ZB-1:0] zbuf_wr_data;
    logic [L*KB-1:0] fb_wr_data;
    logic [L-1:0] zbuf_wr_mask, fb_wr_mask;

    logic [ZB-1:0] zmem [NPIX];
    logic [KB-1:0] fbmem [NPIX];
    logic [ZB-1:0] ref_z [NPIX];
    logic [KB-1:0] ref_fb [NPIX];
    logic clr_mem = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    raster_span_engine dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_ax(tri_ax), .tri_ay(tri_ay), .tri_bx(tri_bx), .tri_by(tri_by), .tri_cx(tri_cx), .tri_cy(tri_cy),
        .tri_z(tri_z), .tri_color(tri_color), .busy(busy), .tri_done(tri_done),
        .zbuf_rd_en(zbuf_rd_en), .zbuf_rd_addr(zbuf_rd_addr), .zbuf_rd_data(zbuf_rd_data),
        .zbuf_wr_en(zbuf_wr_en), .zbuf_wr_addr(zbuf_wr_addr), .zbuf_wr_data(zbuf_wr_data), .zbuf_wr_mask(zbuf_wr_mask),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_mask(fb_wr_mask)
    );

    always #5 clk = ~clk;

    // RAM models: 1-cycle read latency, masked lane writes.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int p = 0; p < NPIX; p++) begin
                zmem[p] <= 16'hFFFF;
                fbmem[p] <= '0;
            end
        end else begin
            if (zbuf_rd_en)
                for (int i = 0; i < L; i++) zbuf_rd_data[i*ZB +: ZB] <= zmem[int'(zbuf_rd_addr) * L + i];
            if (zbuf_wr_en)
                for (int i = 0; i < L; i++) if (zbuf_wr_mask[i]) zmem[int'(zbuf_wr_addr) * L + i] <= zbuf_wr_data[i*ZB +: ZB];
            if (fb_wr_en)
                for (int i = 0; i < L; i++) if (fb_wr_mask[i]) fbmem[int'(fb_wr_addr) * L + i] <= fb_wr_data[i*KB +: KB];
        end
    end

    task automatic init_mem();
        for (int p = 0; p < NPIX; p++) begin
            ref_z[p] = 16'hFFFF;
            ref_fb[p] = '0;
        end
        @(negedge clk);
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    // Reference rasteriser: brute-force per-pixel edge tests over the clamped bbox.
    task automatic model(input int ax, input int ay, input int bx, input int by, input int cx, input int cy,
                         input int z, input int color, output int spans, output int pix, output bit dropped);
        longint area;
        int t, mnx, mxx, mny, mxy, e0, e1, e2;
        area = longint'(bx - ax) * longint'(cy - ay) - longint'(by - ay) * longint'(cx - ax);
        spans = 0;
        pix = 0;
`ifdef RASTER_BACKFACE_CULL_EN
        dropped = area <= 0;
`else
        dropped = area == 0;
        if (area < 0) begin
            t = bx; bx = cx; cx = t;
            t = by; by = cy; cy = t;
        end
`endif
        mnx = ax < bx ? ax : bx; mnx = mnx < cx ? mnx : cx; mnx = mnx < 0 ? 0 : mnx;
        mxx = ax > bx ? ax : bx; mxx = mxx > cx ? mxx : cx; mxx = mxx > W - 1 ? W - 1 : mxx;
        mny = ay < by ? ay : by; mny = mny < cy ? mny : cy; mny = mny < 0 ? 0 : mny;
        mxy = ay > by ? ay : by; mxy = mxy > cy ? mxy : cy; mxy = mxy > H - 1 ? H - 1 : mxy;
        if (mxx < mnx || mxy < mny) dropped = 1'b1;
        if (!dropped) begin
            spans = (mxx / L - mnx / L + 1) * (mxy - mny + 1);
            for (int py = mny; py <= mxy; py++)
                for (int px = mnx; px <= mxx; px++) begin
                    e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
                    e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
                    e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
                    if (e0 >= 0 && e1 >= 0 && e2 >= 0 && z < int'(ref_z[py * W + px])) begin
                        ref_z[py * W + px] = ZB'(z);
                        ref_fb[py * W + px] = KB'(color);
                        pix++;
                    end
                end
        end
    endtask

    function automatic int mem_diff();
        for (int p = 0; p < NPIX; p++)
            if (zmem[p] !== ref_z[p] || fbmem[p] !== ref_fb[p]) return p;
        return -1;
    endfunction

    // Offer one triangle, then observe until one cycle past tri_done (or a cycle budget).
    task automatic render(input int ax, input int ay, input int bx, input int by, input int cx, input int cy,
                          input int z, input int color, output int lat, output int reads, output int wrs,
                          output int pix, output int dones);
        @(negedge clk);
        tri_ax = CB'(ax); tri_ay = CB'(ay); tri_bx = CB'(bx); tri_by = CB'(by);
        tri_cx = CB'(cx); tri_cy = CB'(cy); tri_z = ZB'(z); tri_color = KB'(color);
        tri_valid = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
        lat = 0; reads = 0; wrs = 0; pix = 0; dones = 0;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            reads += int'(zbuf_rd_en);
            wrs += int'(zbuf_wr_en);
            if (fb_wr_en) pix += $countones(fb_wr_mask);
            if (tri_done) begin
                dones++;
                if (lat == 0) lat = n;
            end
            if (lat != 0 && n >= lat + 1) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (tri_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", tri_ready); else n_pass++;
        n_checks++;
        if ({busy, tri_done, zbuf_rd_en, zbuf_wr_en, fb_wr_en, zbuf_rd_addr, zbuf_wr_addr, zbuf_wr_data,
             zbuf_wr_mask, fb_wr_addr, fb_wr_data, fb_wr_mask} !== '0)
            $display("FAIL reset_outputs got nonzero busy=%b rd=%b wr=%b fb=%b exp all 0", busy, zbuf_rd_en, zbuf_wr_en, fb_wr_en);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, reads, wrs, pix, dones, es, ep, d;
        bit dr;
        init_mem();
        model(0, 0, 0, 7, 7, 0, 100, 16'h1234, es, ep, dr);
        render(0, 0, 0, 7, 7, 0, 100, 16'h1234, lat, reads, wrs, pix, dones);
        n_checks++; if (pix !== 36) $display("FAIL basic_pixels got %0d exp 36", pix); else n_pass++;
        n_checks++; if (reads !== 16) $display("FAIL basic_reads got %0d exp 16", reads); else n_pass++;
        n_checks++; if (dones !== 1) $display("FAIL basic_done_pulses got %0d exp 1", dones); else n_pass++;
        n_checks++; if (lat !== 19) $display("FAIL basic_latency got %0d exp 19", lat); else n_pass++;
        n_checks++; if (tri_ready !== 1'b1) $display("FAIL basic_ready_after got %b exp 1", tri_ready); else n_pass++;
        d = mem_diff();
        n_checks++; if (d !== -1) $display("FAIL basic_memory first bad pixel %0d exp none", d); else n_pass++;
    endtask

    task automatic test_depth_equal();
        int lat, reads, wrs, pix, dones, es, ep, d;
        bit dr;
        model(0, 0, 0, 7, 7, 0, 100, 16'h5555, es, ep, dr);
        render(0, 0, 0, 7, 7, 0, 100, 16'h5555, lat, reads, wrs, pix, dones);
        n_checks++; if (wrs !== 0) $display("FAIL equal_z_writes got %0d exp 0", wrs); else n_pass++;
        n_checks++; if (reads !== 16) $display("FAIL equal_z_reads got %0d exp 16", reads); else n_pass++;
        model(0, 0, 0, 7, 7, 0, 99, 16'h0F0F, es, ep, dr);
        render(0, 0, 0, 7, 7, 0, 99, 16'h0F0F, lat, reads, wrs, pix, dones);
        n_checks++; if (pix !== 36) $display("FAIL nearer_z_pixels got %0d exp 36", pix); else n_pass++;
        d = mem_diff();
        n_checks++; if (d !== -1) $display("FAIL nearer_z_memory first bad pixel %0d exp none", d); else n_pass++;
    endtask

    task automatic test_dropped();
        int lat, reads, wrs, pix, dones;
        render(-50, -50, -50, -10, -10, -50, 5, 1, lat, reads, wrs, pix, dones);
        n_checks++; if (reads + wrs !== 0) $display("FAIL offscreen_traffic got %0d exp 0", reads + wrs); else n_pass++;
        n_checks++; if (lat < 1 || lat > 3) $display("FAIL offscreen_latency got %0d exp 1..3", lat); else n_pass++;
        n_checks++; if (dones !== 1) $display("FAIL offscreen_done_pulses got %0d exp 1", dones); else n_pass++;
        render(0, 0, 5, 5, 10, 10, 5, 1, lat, reads, wrs, pix, dones);
        n_checks++; if (reads + wrs !== 0) $display("FAIL collinear_traffic got %0d exp 0", reads + wrs); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL collinear_latency got %0d exp 2", lat); else n_pass++;
    endtask

    task automatic test_winding();
        int lat, reads, wrs, pix, dones, es, ep, d;
        bit dr;
        init_mem();
        model(0, 0, 7, 0, 0, 7, 100, 16'hBEEF, es, ep, dr);
        render(0, 0, 7, 0, 0, 7, 100, 16'hBEEF, lat, reads, wrs, pix, dones);
        n_checks++; if (pix !== ep) $display("FAIL winding_pixels got %0d exp %0d", pix, ep); else n_pass++;
        d = mem_diff();
        n_checks++; if (d !== -1) $display("FAIL winding_memory first bad pixel %0d exp none", d); else n_pass++;
    endtask

    task automatic test_random();
        int ax, ay, bx, by, cx, cy, z, col, bxb, byb;
        int lat, reads, wrs, pix, dones, es, ep, d;
        bit dr;
        init_mem();
        for (int t = 0; t < 25; t++) begin
            bxb = int'($urandom_range(0, 200)) - 20;
            byb = int'($urandom_range(0, 150)) - 20;
            ax = bxb + int'($urandom_range(0, 60)) - 30; ay = byb + int'($urandom_range(0, 60)) - 30;
            bx = bxb + int'($urandom_range(0, 60)) - 30; by = byb + int'($urandom_range(0, 60)) - 30;
            cx = bxb + int'($urandom_range(0, 60)) - 30; cy = byb + int'($urandom_range(0, 60)) - 30;
            z = int'($urandom_range(0, 65535));
            col = int'($urandom_range(0, 65535));
            model(ax, ay, bx, by, cx, cy, z, col, es, ep, dr);
            render(ax, ay, bx, by, cx, cy, z, col, lat, reads, wrs, pix, dones);
            n_checks++; if (reads !== es) $display("FAIL rand%0d_reads got %0d exp %0d", t, reads, es); else n_pass++;
            n_checks++; if (pix !== ep) $display("FAIL rand%0d_pixels got %0d exp %0d", t, pix, ep); else n_pass++;
            n_checks++; if (dones !== 1) $display("FAIL rand%0d_done_pulses got %0d exp 1", t, dones); else n_pass++;
            n_checks++; if (lat !== (dr ? 2 : es + 3)) $display("FAIL rand%0d_latency got %0d exp %0d", t, lat, dr ? 2 : es + 3); else n_pass++;
            d = mem_diff();
            n_checks++; if (d !== -1) $display("FAIL rand%0d_memory first bad pixel %0d exp none", t, d); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, reads, wrs, pix, dones, es, ep, d, stray;
        bit dr;
        init_mem();
        @(negedge clk);
        tri_ax = 0; tri_ay = 0; tri_bx = 100; tri_by = 0; tri_cx = 0; tri_cy = 100;
        tri_z = 10; tri_color = 16'hAAAA;
        tri_valid = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
        repeat (30) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, tri_done, zbuf_rd_en, zbuf_wr_en, fb_wr_en, zbuf_rd_addr, zbuf_wr_addr, zbuf_wr_data,
             zbuf_wr_mask, fb_wr_addr, fb_wr_data, fb_wr_mask} !== '0)
            $display("FAIL midscan_outputs got nonzero busy=%b rd=%b wr=%b fb=%b exp all 0", busy, zbuf_rd_en, zbuf_wr_en, fb_wr_en);
        else n_pass++;
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            stray += int'(zbuf_wr_en) + int'(fb_wr_en) + int'(zbuf_rd_en);
        end
        n_checks++; if (stray !== 0) $display("FAIL midscan_stray_strobes got %0d exp 0", stray); else n_pass++;
        n_checks++; if (tri_ready !== 1'b1) $display("FAIL midscan_ready got %b exp 1", tri_ready); else n_pass++;
        init_mem();
        model(0, 0, 0, 7, 7, 0, 100, 16'h7777, es, ep, dr);
        render(0, 0, 0, 7, 7, 0, 100, 16'h7777, lat, reads, wrs, pix, dones);
        n_checks++; if (pix !== 36) $display("FAIL post_reset_pixels got %0d exp 36", pix); else n_pass++;
        d = mem_diff();
        n_checks++; if (d !== -1) $display("FAIL post_reset_memory first bad pixel %0d exp none", d); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_depth_equal();
        test_dropped();
        test_winding();
        test_random();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
